// File: rtl/mips_fetch_unit.sv
// Instruction fetch and next-PC sequencer: imem req/ready on one side, valid/ack to the core.
// Optional macro FETCH_ALIGN_CHECK_EN flags and clears misaligned next-PC targets.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_ack,
  input  logic        jump,
  input  logic        jr,
  input  logic        branch,
  input  logic        nequal,
  input  logic        bclt,
  input  logic        zero,
  input  logic        fp_cond,
  input  logic [31:0] rs_data,
  output logic        fetch_err,
  output logic        align_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StRetry, StHold} state_e;

  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        imem_req_q;
  logic        fetch_err_q;

  logic [31:0] br_target;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc_load;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    next_pc_raw = pc_plus4;
    if (jr) begin
      next_pc_raw = rs_data;
    end else if (jump) begin
      next_pc_raw = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    end else if (bclt && (fp_cond == inst_q[16])) begin
      next_pc_raw = br_target;
    end else if (branch && (zero ^ nequal)) begin
      next_pc_raw = br_target;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q;
  assign next_pc_load = {next_pc_raw[31:2], 2'b00};
  assign align_err    = align_err_q;

  // Only a jr target can carry low bits; flag it once the core commits to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_q <= 1'b0;
    end else if (state_q == StHold && inst_ack && (next_pc_raw[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end
`else
  assign next_pc_load = next_pc_raw;
  assign align_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_cnt_q   <= 8'd0;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
          wait_cnt_q <= 8'd0;
        end
        StFetch: begin
          if (imem_ready) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
            imem_req_q   <= 1'b0;
            wait_cnt_q   <= 8'd0;
            state_q      <= StHold;
          end else if (wait_cnt_q == WaitLast) begin
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            wait_cnt_q  <= 8'd0;
            state_q     <= StRetry;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StRetry: begin
          imem_req_q <= 1'b1;
          wait_cnt_q <= 8'd0;
          state_q    <= StFetch;
        end
        StHold: begin
          if (inst_ack) begin
            pc_q         <= next_pc_load;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            state_q      <= StFetch;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a transaction-level PC/instruction model.
module tb_mips_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam int unsigned WaitMax = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_ack;
  logic        jump, jr, branch, nequal, bclt, zero, fp_cond;
  logic [31:0] rs_data;
  logic        fetch_err;
  logic        align_err;

  mips_fetch_unit #(
    .RESET_PC(ResetPc),
    .WAIT_MAX(WaitMax)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst      (inst),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .inst_ack  (inst_ack),
    .jump      (jump),
    .jr        (jr),
    .branch    (branch),
    .nequal    (nequal),
    .bclt      (bclt),
    .zero      (zero),
    .fp_cond   (fp_cond),
    .rs_data   (rs_data),
    .fetch_err (fetch_err),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Next-PC straight from the redirect rules, using the model's own pc and word.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w);
    logic [31:0] p4;
    logic [31:0] off;
    logic [31:0] r;
    p4  = p + 32'd4;
    off = 32'($signed(w[15:0])) * 32'd4;
    if (jr) r = rs_data;
    else if (jump) r = (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
    else if (bclt && (fp_cond == w[16])) r = p4 + off;
    else if (branch && (zero != nequal)) r = p4 + off;
    else r = p4;
    return r;
  endfunction

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_ferr;
  logic        m_aerr;
  int          m_run;

  // Compare process: all DUT outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = ResetPc; m_valid = 1'b0; m_ferr = 1'b0; m_aerr = 1'b0; m_run = 0;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    end else begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
      if (inst_valid) chk("inst", inst, word_at(m_pc));
      chk("req_and_valid", {31'd0, imem_req & inst_valid}, 32'd0);
      chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_ferr});
      chk("align_err", {31'd0, align_err}, {31'd0, m_aerr});
      if (inst_valid && inst_ack) begin
        m_pc = model_next(m_pc, word_at(m_pc));
`ifdef FETCH_ALIGN_CHECK_EN
        if (m_pc[1:0] != 2'b00) m_aerr = 1'b1;
        m_pc = m_pc & 32'hFFFF_FFFC;
`endif
        m_valid = 1'b0;
      end else if (imem_req && imem_ready) begin
        m_valid = 1'b1;
        m_run   = 0;
      end else if (imem_req) begin
        m_run++;
        if (m_run == int'(WaitMax)) begin
          m_ferr = 1'b1;
          m_run  = 0;
        end
      end
    end
    imem_rdata = word_at(imem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    if (!inst_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_ack(input logic j, input logic r, input logic b, input logic ne,
                        input logic bc, input logic z, input logic fp, input logic [31:0] rs);
    wait_valid();
    jump = j; jr = r; branch = b; nequal = ne; bclt = bc; zero = z; fp_cond = fp;
    rs_data = rs; inst_ack = 1'b1;
    step();
    inst_ack = 1'b0; jump = 1'b0; jr = 1'b0; branch = 1'b0; nequal = 1'b0;
    bclt = 1'b0; zero = 1'b0; fp_cond = 1'b0; rs_data = 32'hDEAD_BEEF;
  endtask

  task automatic expect_addr(input string name, input logic [31:0] exp);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      step();
      n++;
    end
    chk(name, imem_addr, exp);
  endtask

  initial begin
    logic [5:0] obs;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; imem_ready = 1'b1; inst_ack = 1'b0;
    jump = 1'b0; jr = 1'b0; branch = 1'b0; nequal = 1'b0; bclt = 1'b0;
    zero = 1'b0; fp_cond = 1'b0; rs_data = 32'd0;
    mem[32'h0040_0000] = 32'h2408_0001;
    mem[32'h0040_0010] = 32'h1000_FFFE;  // beq, imm -2
    mem[32'h0040_0020] = 32'h0810_0003;  // j, target field 0x0100003
    mem[32'h0040_0100] = 32'h4501_0003;  // bc1t, imm 3
    mem[32'h0040_0104] = 32'h4501_0003;

    repeat (3) step();
    chk("reset_pc", pc, 32'h0040_0000);
    chk("reset_inst", inst, 32'd0);
    chk("reset_ferr", {31'd0, fetch_err}, 32'd0);

    rst_n = 1'b1;
    #3;
    chk("idle_no_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    step();
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_inst", inst, 32'h2408_0001);
    chk("first_pc_plus4", pc_plus4, 32'h0040_0004);

    do_ack(0, 0, 0, 0, 0, 0, 0, 32'd0);
    expect_addr("seq_1", 32'h0040_0004);
    do_ack(0, 0, 0, 0, 0, 0, 0, 32'd0);
    expect_addr("seq_2", 32'h0040_0008);
    do_ack(0, 1, 0, 0, 0, 0, 0, 32'h0040_0010);
    expect_addr("jr_to_beq", 32'h0040_0010);
    do_ack(0, 0, 1, 0, 0, 1, 0, 32'd0);
    expect_addr("beq_taken", 32'h0040_000C);
    do_ack(0, 0, 0, 0, 0, 0, 0, 32'd0);
    expect_addr("seq_3", 32'h0040_0010);
    do_ack(0, 0, 1, 1, 0, 1, 0, 32'd0);
    expect_addr("bne_not_taken", 32'h0040_0014);
    do_ack(0, 1, 0, 0, 0, 0, 0, 32'h0040_0020);
    expect_addr("jr_to_j", 32'h0040_0020);
    do_ack(1, 0, 0, 0, 0, 0, 0, 32'd0);
    expect_addr("jump", 32'h0040_000C);
    do_ack(1, 1, 0, 0, 0, 0, 0, 32'h0040_0100);
    expect_addr("jr_over_jump", 32'h0040_0100);
    do_ack(0, 0, 0, 0, 1, 0, 0, 32'd0);
    expect_addr("bclt_not_taken", 32'h0040_0104);
    do_ack(0, 0, 0, 0, 1, 0, 1, 32'd0);
    expect_addr("bclt_taken", 32'h0040_0114);

    // Timeout: four request cycles, one dead cycle, then re-request at the same pc.
    wait_valid();
    imem_ready = 1'b0;
    do_ack(0, 0, 0, 0, 0, 0, 0, 32'd0);
    obs = 6'd0;
    for (int i = 0; i < 6; i++) begin
      obs[5-i] = imem_req;
      if (i < 5) step();
    end
    chk("timeout_req_pattern", {26'd0, obs}, {26'd0, 6'b111101});
    chk("retry_addr", imem_addr, 32'h0040_0118);
    chk("timeout_ferr", {31'd0, fetch_err}, 32'd1);
    imem_ready = 1'b1;
    wait_valid();
    chk("after_retry_inst", inst, 32'h5A1A_0E17);

    // Reset while a fetch is outstanding.
    imem_ready = 1'b0;
    do_ack(0, 0, 0, 0, 0, 0, 0, 32'd0);
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_pc", pc, 32'h0040_0000);
    chk("async_rst_ferr", {31'd0, fetch_err}, 32'd0);
    step();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    expect_addr("refetch_after_reset", 32'h0040_0000);

    do_ack(0, 1, 0, 0, 0, 0, 0, 32'h0040_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    expect_addr("jr_misaligned", 32'h0040_0100);
    chk("align_err_set", {31'd0, align_err}, 32'd1);
`else
    expect_addr("jr_misaligned", 32'h0040_0102);
    chk("align_err_tied", {31'd0, align_err}, 32'd0);
`endif

    do_ack(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    wait_valid();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
